// File: rtl/window_coord_gen.sv
// window_coord_gen: walks every output window of a convolution and every
// kernel tap inside it, one tap per accepted handshake, emitting the signed
// input-feature-map row/column of the tap and its linear address.
module window_coord_gen #(
  parameter int COORD_WIDTH = 16,
  parameter int ADDR_WIDTH  = 16,
  parameter int KW          = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [COORD_WIDTH-1:0] img_height,
  input  logic [COORD_WIDTH-1:0] img_width,
  input  logic [KW-1:0]          kernel_size,
  input  logic [KW-1:0]          stride,
  input  logic [KW-1:0]          pad,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [COORD_WIDTH-1:0] row_coord,
  output logic [COORD_WIDTH-1:0] col_coord,
  output logic [ADDR_WIDTH-1:0]  addr,
  output logic [KW-1:0]          k_row,
  output logic [KW-1:0]          k_col,
  output logic                   first_tap,
  output logic                   last_tap,
  output logic                   last_window,
  output logic                   busy,
  output logic                   done,
  output logic                   cfg_err
);

  // Signed working width: one guard bit above the coordinate width.
  localparam int EW = COORD_WIDTH + 1;
  // Unsigned width wide enough for H + 2P without overflow.
  localparam int LW = COORD_WIDTH + 2;

  typedef enum logic {IDLE, RUN} state_t;

  state_t                  state_q, state_d;
  logic [COORD_WIDTH-1:0]  h_q, h_d, w_q, w_d;
  logic [KW-1:0]           k_q, k_d, s_q, s_d, p_q, p_d;
  logic signed [EW-1:0]    brow_q, brow_d, bcol_q, bcol_d;
  logic [KW-1:0]           krow_q, krow_d, kcol_q, kcol_d;
  logic                    valid_q, valid_d, busy_q, busy_d;
  logic                    done_q, done_d, err_q, err_d;
  logic                    upd;

  logic [COORD_WIDTH-1:0]  row_q, row_d, col_q, col_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                    first_q, first_d, last_q, last_d, lastw_q, lastw_d;

  logic signed [EW-1:0]    row_sum, col_sum;
  logic [LW-1:0]           h_span, w_span;
  logic                    cfg_legal;

  // A further window exists along an axis when base + S + K <= dim + P.
  function automatic logic has_next(input logic signed [EW-1:0] base,
                                    input logic [KW-1:0] s,
                                    input logic [KW-1:0] k,
                                    input logic [KW-1:0] p,
                                    input logic [COORD_WIDTH-1:0] dim);
    logic signed [EW-1:0] lhs, rhs;
    lhs = base + $signed(EW'(s)) + $signed(EW'(k));
    rhs = $signed(EW'(dim)) + $signed(EW'(p));
    return lhs <= rhs;
  endfunction

  // Config legality on the raw inputs, judged at the start request.
  always_comb begin
    h_span    = LW'(img_height) + LW'({pad, 1'b0});
    w_span    = LW'(img_width)  + LW'({pad, 1'b0});
    cfg_legal = (kernel_size != '0) && (stride != '0) &&
                (h_span >= LW'(kernel_size)) && (w_span >= LW'(kernel_size));
  end

  // Next-state logic: run control, config latch and tap/window advance.
  always_comb begin
    state_d = state_q;
    h_d     = h_q;
    w_d     = w_q;
    k_d     = k_q;
    s_d     = s_q;
    p_d     = p_q;
    brow_d  = brow_q;
    bcol_d  = bcol_q;
    krow_d  = krow_q;
    kcol_d  = kcol_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = err_q;
    upd     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (cfg_legal) begin
            state_d = RUN;
            h_d     = img_height;
            w_d     = img_width;
            k_d     = kernel_size;
            s_d     = stride;
            p_d     = pad;
            brow_d  = -$signed(EW'(pad));
            bcol_d  = -$signed(EW'(pad));
            krow_d  = '0;
            kcol_d  = '0;
            valid_d = 1'b1;
            busy_d  = 1'b1;
            err_d   = 1'b0;
            upd     = 1'b1;
          end else begin
            err_d  = 1'b1;
            done_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (out_ready) begin
          if (last_q && lastw_q) begin
            state_d = IDLE;
            valid_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            upd = 1'b1;
            if (kcol_q != k_q - KW'(1)) begin
              kcol_d = kcol_q + KW'(1);
            end else begin
              kcol_d = '0;
              if (krow_q != k_q - KW'(1)) begin
                krow_d = krow_q + KW'(1);
              end else begin
                krow_d = '0;
                if (has_next(bcol_q, s_q, k_q, p_q, w_q)) begin
                  bcol_d = bcol_q + $signed(EW'(s_q));
                end else begin
                  bcol_d = -$signed(EW'(p_q));
                  brow_d = brow_q + $signed(EW'(s_q));
                end
              end
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Tap outputs derived from the next counter values, registered below.
  always_comb begin
    row_sum = brow_d + $signed(EW'(krow_d));
    col_sum = bcol_d + $signed(EW'(kcol_d));
    row_d   = row_sum[COORD_WIDTH-1:0];
    col_d   = col_sum[COORD_WIDTH-1:0];
    addr_d  = ADDR_WIDTH'(row_sum) * ADDR_WIDTH'(w_d) + ADDR_WIDTH'(col_sum);
    first_d = (krow_d == '0) && (kcol_d == '0);
    last_d  = (krow_d == k_d - KW'(1)) && (kcol_d == k_d - KW'(1));
    lastw_d = !has_next(bcol_d, s_d, k_d, p_d, w_d) &&
              !has_next(brow_d, s_d, k_d, p_d, h_d);
  end

  // State, counters and registered outputs; tap fields load only on advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      h_q     <= '0;
      w_q     <= '0;
      k_q     <= '0;
      s_q     <= '0;
      p_q     <= '0;
      brow_q  <= '0;
      bcol_q  <= '0;
      krow_q  <= '0;
      kcol_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      row_q   <= '0;
      col_q   <= '0;
      addr_q  <= '0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
      lastw_q <= 1'b0;
    end else begin
      state_q <= state_d;
      h_q     <= h_d;
      w_q     <= w_d;
      k_q     <= k_d;
      s_q     <= s_d;
      p_q     <= p_d;
      brow_q  <= brow_d;
      bcol_q  <= bcol_d;
      krow_q  <= krow_d;
      kcol_q  <= kcol_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      if (upd) begin
        row_q   <= row_d;
        col_q   <= col_d;
        addr_q  <= addr_d;
        first_q <= first_d;
        last_q  <= last_d;
        lastw_q <= lastw_d;
      end
    end
  end

  assign out_valid   = valid_q;
  assign row_coord   = row_q;
  assign col_coord   = col_q;
  assign addr        = addr_q;
  assign k_row       = krow_q;
  assign k_col       = kcol_q;
  assign first_tap   = first_q;
  assign last_tap    = last_q;
  assign last_window = lastw_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign cfg_err     = err_q;

endmodule

// File: tb/tb_window_coord_gen.sv
// Testbench for window_coord_gen: scoreboard of expected taps built from a
// window/tap enumeration, drained by an independent monitor.
module tb_window_coord_gen;

  localparam int LIMIT = 6000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] img_height, img_width;
  logic [3:0]  kernel_size, stride, pad;
  logic        out_valid, out_ready;
  logic [15:0] row_coord, col_coord, addr;
  logic [3:0]  k_row, k_col;
  logic        first_tap, last_tap, last_window, busy, done, cfg_err;

  window_coord_gen #(.COORD_WIDTH(16), .ADDR_WIDTH(16), .KW(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .img_height(img_height), .img_width(img_width),
    .kernel_size(kernel_size), .stride(stride), .pad(pad),
    .out_valid(out_valid), .out_ready(out_ready),
    .row_coord(row_coord), .col_coord(col_coord), .addr(addr),
    .k_row(k_row), .k_col(k_col),
    .first_tap(first_tap), .last_tap(last_tap), .last_window(last_window),
    .busy(busy), .done(done), .cfg_err(cfg_err)
  );

  typedef struct {
    int row; int col; int addr; int kr; int kc;
    bit first; bit last; bit lastw; bit fin;
  } tap_t;

  tap_t exp_q[$];
  int   tests = 0, fails = 0;
  int   cyc = 0, n_pop_run = 0, first_cyc = 0, last_cyc = 0;
  bit   final_pend = 0, final_popped = 0, allow_done = 0, bp = 0;
  bit   prev_v = 0, prev_r = 0;
  logic [59:0] snap;
  int   cap_row[1024], cap_col[1024], cap_addr[1024];
  bit   cap_first[1024], cap_last[1024], cap_lastw[1024];

  initial forever #5 clk = ~clk;

  task automatic chk(input string nm, input bit ok, input longint act, input longint req);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", nm, act, req, $time);
    end
  endtask

  function automatic logic [59:0] outs();
    return {row_coord, col_coord, addr, k_row, k_col, first_tap, last_tap, last_window, out_valid};
  endfunction

  function automatic bit all_zero();
    return {out_valid, row_coord, col_coord, addr, k_row, k_col, first_tap,
            last_tap, last_window, busy, done, cfg_err} == '0;
  endfunction

  // Ready driver: always high, or random when backpressure is enabled.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1 out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: pops and compares on every transfer, checks stalls and run end.
  initial begin
    tap_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        prev_v = 0;
        final_pend = 0;
      end else begin
        if (final_pend) begin
          chk("run_end_done", done && !out_valid && !busy, {done, out_valid, busy}, 3'b100);
          final_pend = 0;
        end else if (done && !allow_done) begin
          chk("unexpected_done", 1'b0, done, 0);
        end
        if (prev_v && !prev_r)
          chk("stall_stable", outs() == snap, outs(), snap);
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_tap", 1'b0, $signed(row_coord), 0);
          end else begin
            e = exp_q.pop_front();
            tests++;
            if (!(int'($signed(row_coord)) == e.row && int'($signed(col_coord)) == e.col &&
                  int'(addr) == e.addr && int'(k_row) == e.kr && int'(k_col) == e.kc &&
                  first_tap == e.first && last_tap == e.last && last_window == e.lastw && busy)) begin
              fails++;
              $display("FAIL tap%0d: got r=%0d c=%0d a=%0h k=%0d,%0d f/l/lw=%b%b%b busy=%b, required r=%0d c=%0d a=%0h k=%0d,%0d f/l/lw=%b%b%b",
                       n_pop_run, $signed(row_coord), $signed(col_coord), addr, k_row, k_col,
                       first_tap, last_tap, last_window, busy,
                       e.row, e.col, e.addr, e.kr, e.kc, e.first, e.last, e.lastw);
            end
            if (n_pop_run < 1024) begin
              cap_row[n_pop_run]   = int'($signed(row_coord));
              cap_col[n_pop_run]   = int'($signed(col_coord));
              cap_addr[n_pop_run]  = int'(addr);
              cap_first[n_pop_run] = first_tap;
              cap_last[n_pop_run]  = last_tap;
              cap_lastw[n_pop_run] = last_window;
            end
            if (n_pop_run == 0) first_cyc = cyc;
            last_cyc = cyc;
            n_pop_run++;
            if (e.fin) begin
              final_pend = 1;
              final_popped = 1;
            end
          end
        end
        prev_v = out_valid;
        prev_r = out_ready;
        snap   = outs();
      end
    end
  end

  // Reference model: enumerate windows and taps with plain arithmetic.
  task automatic push_model(input int h, w, k, s, p);
    tap_t t;
    int nr, nc;
    nr = (h + 2 * p - k) / s + 1;
    nc = (w + 2 * p - k) / s + 1;
    for (int wr = 0; wr < nr; wr++)
      for (int wc = 0; wc < nc; wc++)
        for (int kr = 0; kr < k; kr++)
          for (int kc = 0; kc < k; kc++) begin
            t.row   = -p + wr * s + kr;
            t.col   = -p + wc * s + kc;
            t.addr  = (t.row * w + t.col) & 32'hFFFF;
            t.kr    = kr;
            t.kc    = kc;
            t.first = (kr == 0 && kc == 0);
            t.last  = (kr == k - 1 && kc == k - 1);
            t.lastw = (wr == nr - 1 && wc == nc - 1);
            t.fin   = t.last && t.lastw;
            exp_q.push_back(t);
          end
  endtask

  // One run; called and returns aligned to a rising edge.
  task automatic do_run(input int h, w, k, s, p, input int ign_at, input int rst_at, output int npop);
    int cnt;
    bit ign_done, aborted;
    push_model(h, w, k, s, p);
    final_popped = 0;
    n_pop_run = 0;
    #1;
    img_height = 16'(h); img_width = 16'(w);
    kernel_size = 4'(k); stride = 4'(s); pad = 4'(p);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    cnt = 0; ign_done = 0; aborted = 0;
    while (!final_popped && !aborted && cnt < LIMIT) begin
      @(posedge clk);
      cnt++;
      if (ign_at >= 0 && !ign_done && n_pop_run >= ign_at) begin
        ign_done = 1;
        #1;
        img_height = 16'd9; img_width = 16'd9; kernel_size = 4'd1; stride = 4'd2; pad = 4'd0;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        img_height = 16'(h); img_width = 16'(w);
        kernel_size = 4'(k); stride = 4'(s); pad = 4'(p);
      end
      if (rst_at >= 0 && n_pop_run >= rst_at) begin
        #3 rst_n = 1'b0;
        #1 chk("reset_midrun_zero", all_zero(), outs(), 0);
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1 chk("no_done_after_reset", !done && !out_valid, {done, out_valid}, 0);
        @(posedge clk);
        aborted = 1;
      end
    end
    if (cnt >= LIMIT) chk("run_timeout", 1'b0, cnt, LIMIT);
    npop = n_pop_run;
  endtask

  initial begin
    int np, h, w, k, s, p, kmax;
    rst_n = 1'b0; start = 1'b0;
    img_height = '0; img_width = '0; kernel_size = '0; stride = '0; pad = '0;
    #12 chk("reset_state", all_zero(), outs(), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("idle_after_reset", all_zero(), outs(), 0);
    @(posedge clk);

    // Scenario 1: H=W=4 K=3 S=1 P=1, no backpressure.
    do_run(4, 4, 3, 1, 1, -1, -1, np);
    chk("s1_count", np == 144, np, 144);
    chk("s1_first_tap", cap_row[0] == -1 && cap_col[0] == -1 && cap_addr[0] == 'hFFFB && cap_first[0],
        cap_addr[0], 'hFFFB);
    chk("s1_final_tap", cap_row[143] == 4 && cap_col[143] == 4 && cap_addr[143] == 20 &&
        cap_last[143] && cap_lastw[143], cap_addr[143], 20);
    chk("s1_back_to_back", last_cyc - first_cyc == 143, last_cyc - first_cyc, 143);

    // Scenario 2: H=W=5 K=3 S=2 P=0; starts in the done cycle of scenario 1.
    do_run(5, 5, 3, 2, 0, -1, -1, np);
    chk("s2_count", np == 36, np, 36);
    chk("s2_tap10", cap_row[9] == 0 && cap_col[9] == 2 && cap_first[9], cap_col[9], 2);

    // Backpressure on scenario 1.
    bp = 1;
    do_run(4, 4, 3, 1, 1, -1, -1, np);
    chk("bp_count", np == 144, np, 144);
    bp = 0;
    repeat (2) @(posedge clk);

    // Illegal config K=7 H=W=4 P=1.
    #1;
    img_height = 16'd4; img_width = 16'd4; kernel_size = 4'd7; stride = 4'd1; pad = 4'd1;
    allow_done = 1; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    chk("illegal_err_done", done && cfg_err && !out_valid && !busy, {done, cfg_err, out_valid, busy}, 4'b1100);
    @(posedge clk);
    #1 allow_done = 0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("illegal_sticky", cfg_err && !out_valid && !done, {cfg_err, out_valid, done}, 3'b100);
    @(posedge clk);
    do_run(5, 5, 3, 2, 0, -1, -1, np);
    chk("legal_clears_err", !cfg_err, cfg_err, 0);
    chk("after_illegal_count", np == 36, np, 36);

    // Start ignored at tap 20, reset at tap 50, then a fresh run.
    do_run(4, 4, 3, 1, 1, 20, 50, np);
    chk("reset_stopped_run", np >= 50 && np < 144, np, 50);
    do_run(4, 4, 3, 1, 1, -1, -1, np);
    chk("restart_count", np == 144, np, 144);
    chk("restart_origin", cap_row[0] == -1 && cap_col[0] == -1, cap_row[0], -1);

    // Randomized legal configurations with random backpressure.
    for (int i = 0; i < 15; i++) begin
      h = $urandom_range(1, 6);
      w = $urandom_range(1, 6);
      p = $urandom_range(0, 2);
      s = $urandom_range(1, 3);
      kmax = ((h < w ? h : w) + 2 * p);
      if (kmax > 4) kmax = 4;
      k = $urandom_range(1, kmax);
      bp = 1'($urandom_range(0, 1));
      do_run(h, w, k, s, p, -1, -1, np);
      chk("rand_count", np == ((h + 2 * p - k) / s + 1) * ((w + 2 * p - k) / s + 1) * k * k,
          np, ((h + 2 * p - k) / s + 1) * ((w + 2 * p - k) / s + 1) * k * k);
    end
    bp = 0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("scoreboard_empty", exp_q.size() == 0, exp_q.size(), 0);
    chk("idle_at_end", !busy && !out_valid, {busy, out_valid}, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
